// File: rtl/dcache_pkg.sv
// dcache_pkg: shared definitions for the direct-mapped write-back L1 data cache.
// Holds the geometry constants, the controller state encoding and helpers
// that split a 32-bit byte address into tag / index / word fields.
package dcache_pkg;

    localparam int NUM_LINES      = 32;
    localparam int IDX_W          = $clog2(NUM_LINES);
    localparam int OFFSET_W       = 5;
    localparam int LINE_BITS      = 256;
    localparam int WORD_BITS      = 32;
    localparam int WORD_SEL_W     = 3;
    localparam int TAG_W          = 32 - IDX_W - OFFSET_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2,
        REFILL    = 2'd3
    } state_e;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] addr);
        return addr[31 -: TAG_W];
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] addr);
        return addr[OFFSET_W +: IDX_W];
    endfunction

    function automatic logic [WORD_SEL_W-1:0] addr_word(input logic [31:0] addr);
        return addr[2 +: WORD_SEL_W];
    endfunction

    function automatic logic [31:0] line_addr(input logic [TAG_W-1:0] tag,
                                              input logic [IDX_W-1:0] idx);
        return {tag, idx, 5'b0_0000};
    endfunction

endpackage

// File: rtl/dcache_sram.sv
// dcache_sram: valid / dirty / tag / data storage for the L1 data cache.
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset (clears valid/dirty only)
//   idx_i                line index used for both read and write
//   rd_*_o               asynchronous read of the indexed line
//   line_we_i            refill: writes whole line + tag, sets valid, clears dirty
//   word_we_i            store hit: writes one word, sets dirty
module dcache_sram
    import dcache_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [IDX_W-1:0]      idx_i,
    output logic                  rd_valid_o,
    output logic                  rd_dirty_o,
    output logic [TAG_W-1:0]      rd_tag_o,
    output logic [LINE_BITS-1:0]  rd_line_o,
    input  logic                  line_we_i,
    input  logic [LINE_BITS-1:0]  line_wdata_i,
    input  logic [TAG_W-1:0]      line_tag_i,
    input  logic                  word_we_i,
    input  logic [WORD_SEL_W-1:0] word_sel_i,
    input  logic [WORD_BITS-1:0]  word_wdata_i
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_BITS-1:0] data_q [NUM_LINES];

    assign rd_valid_o = valid_q[idx_i];
    assign rd_dirty_o = dirty_q[idx_i];
    assign rd_tag_o   = tag_q[idx_i];
    assign rd_line_o  = data_q[idx_i];

    // Line state bits; the only storage that reset touches.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (line_we_i) begin
            valid_q[idx_i] <= 1'b1;
            dirty_q[idx_i] <= 1'b0;
        end else if (word_we_i) begin
            dirty_q[idx_i] <= 1'b1;
        end
    end

    // Tag and data payload; contents are meaningless until the valid bit is set.
    always_ff @(posedge clk_i) begin
        if (line_we_i) begin
            tag_q[idx_i]  <= line_tag_i;
            data_q[idx_i] <= line_wdata_i;
        end else if (word_we_i) begin
            data_q[idx_i][{word_sel_i, 5'b0_0000} +: WORD_BITS] <= word_wdata_i;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate L1 data cache controller.
// Hits complete with no added cycle; a miss freezes the pipeline (cpu_stall_o)
// while the FSM writes back a dirty victim and refills the line over a
// req/ack line-wide memory handshake.
// Ports:
//   clk_i, rst_i                          clock, synchronous active-high reset
//   cpu_req_i/we_i/addr_i/wdata_i         pipeline access (held stable while stalled)
//   cpu_rdata_o, cpu_stall_o              load data, pipeline freeze
//   mem_req_o/we_o/addr_o/wdata_o         line request to main memory
//   mem_rdata_i, mem_ack_i                refill line, one-cycle completion pulse
// Optional macro DCACHE_STATS_EN adds hit_cnt_o / miss_cnt_o saturating counters.
module dcache_ctrl
    import dcache_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cpu_req_i,
    input  logic                 cpu_we_i,
    input  logic [31:0]          cpu_addr_i,
    input  logic [31:0]          cpu_wdata_i,
    output logic [31:0]          cpu_rdata_o,
    output logic                 cpu_stall_o,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [31:0]          mem_addr_o,
    output logic [LINE_BITS-1:0] mem_wdata_o,
    input  logic [LINE_BITS-1:0] mem_rdata_i,
    input  logic                 mem_ack_i
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]          hit_cnt_o,
    output logic [31:0]          miss_cnt_o
`endif
);

    state_e               state_q;
    logic                 mem_req_q;
    logic                 mem_we_q;
    logic [31:0]          mem_addr_q;

    logic [TAG_W-1:0]      cpu_tag_s;
    logic [IDX_W-1:0]      cpu_idx_s;
    logic [WORD_SEL_W-1:0] cpu_word_s;
    logic                  rd_valid_s;
    logic                  rd_dirty_s;
    logic [TAG_W-1:0]      rd_tag_s;
    logic [LINE_BITS-1:0]  rd_line_s;
    logic                  hit_s;
    logic                  line_we_s;
    logic                  word_we_s;

    assign cpu_tag_s  = addr_tag(cpu_addr_i);
    assign cpu_idx_s  = addr_idx(cpu_addr_i);
    assign cpu_word_s = addr_word(cpu_addr_i);

    assign hit_s     = cpu_req_i & rd_valid_s & (rd_tag_s == cpu_tag_s);
    assign line_we_s = (state_q == ALLOCATE) & mem_ack_i;
    // Stores only commit from IDLE, which also covers the post-refill retry.
    assign word_we_s = (state_q == IDLE) & hit_s & cpu_we_i;

    dcache_sram u_sram (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .idx_i        (cpu_idx_s),
        .rd_valid_o   (rd_valid_s),
        .rd_dirty_o   (rd_dirty_s),
        .rd_tag_o     (rd_tag_s),
        .rd_line_o    (rd_line_s),
        .line_we_i    (line_we_s),
        .line_wdata_i (mem_rdata_i),
        .line_tag_i   (cpu_tag_s),
        .word_we_i    (word_we_s),
        .word_sel_i   (cpu_word_s),
        .word_wdata_i (cpu_wdata_i)
    );

    // Miss sequencer with registered memory-request outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= 32'h0000_0000;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cpu_req_i && !hit_s) begin
                        mem_req_q <= 1'b1;
                        if (rd_valid_s && rd_dirty_s) begin
                            state_q    <= WRITEBACK;
                            mem_we_q   <= 1'b1;
                            mem_addr_q <= line_addr(rd_tag_s, cpu_idx_s);
                        end else begin
                            state_q    <= ALLOCATE;
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= line_addr(cpu_tag_s, cpu_idx_s);
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_ack_i) begin
                        state_q    <= ALLOCATE;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= line_addr(cpu_tag_s, cpu_idx_s);
                    end
                end
                ALLOCATE: begin
                    if (mem_ack_i) begin
                        state_q   <= REFILL;
                        mem_req_q <= 1'b0;
                    end
                end
                REFILL: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                end
            endcase
        end
    end

    // Stall and load data are combinational so hits cost no cycle; both are
    // forced to zero while reset is asserted.
    always_comb begin
        cpu_stall_o = 1'b0;
        cpu_rdata_o = 32'h0000_0000;
        if (rst_i) begin
            cpu_stall_o = 1'b0;
            cpu_rdata_o = 32'h0000_0000;
        end else begin
            cpu_stall_o = (state_q != IDLE) | (cpu_req_i & ~hit_s);
            cpu_rdata_o = rd_line_s[{cpu_word_s, 5'b0_0000} +: WORD_BITS];
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = rd_line_s;

`ifdef DCACHE_STATS_EN
    logic        post_refill_q;
    logic [31:0] hit_cnt_q;
    logic [31:0] hit_cnt_d;
    logic [31:0] miss_cnt_q;
    logic [31:0] miss_cnt_d;

    // Saturating next values; the hit that completes a refilled miss is not a hit.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if ((state_q == IDLE) && hit_s && !post_refill_q && (hit_cnt_q != 32'hFFFF_FFFF)) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
        end else begin
            hit_cnt_d = hit_cnt_q;
        end
        if ((state_q == IDLE) && cpu_req_i && !hit_s && (miss_cnt_q != 32'hFFFF_FFFF)) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end else begin
            miss_cnt_d = miss_cnt_q;
        end
    end

    // Counter registers plus a flag marking the cycle right after REFILL.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            post_refill_q <= 1'b0;
            hit_cnt_q     <= 32'h0000_0000;
            miss_cnt_q    <= 32'h0000_0000;
        end else begin
            post_refill_q <= (state_q == REFILL);
            hit_cnt_q     <= hit_cnt_d;
            miss_cnt_q    <= miss_cnt_d;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
Direct-mapped, write-back, write-allocate L1 data cache between the pipeline's EX/MEM stage (DataMemory-port consumer) and a slow line-wide main memory. Serves word hits in zero added cycles. On a miss, asserts a stall that freezes PC, IF/ID, ID/EX, EX/MEM and MEM/WB. Sequences dirty-line writeback and line refill over a req/ack memory handshake.

Parameters:
NUM_LINES, 32, number of cache lines (power of 2); index width IDX_W = log2(NUM_LINES)
LINE_BITS, 256, line size in bits (32 bytes, 8 words); offset width 5
TAG_W, 22, tag width = 32 - IDX_W - 5

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
cpu_req_i  in  1  access request (EX/MEM MemRead | MemWrite)
cpu_we_i  in  1  1 = store, 0 = load
cpu_addr_i  in  32  byte address (EX/MEM ALU result)
cpu_wdata_i  in  32  store data
cpu_rdata_o  out  32  load data to MEM/WB
cpu_stall_o  out  1  pipeline freeze
mem_req_o  out  1  memory request
mem_we_o  out  1  1 = line write, 0 = line read
mem_addr_o  out  32  line-aligned address, bits [4:0] = 0
mem_wdata_o  out  256  writeback line
mem_rdata_i  in  256  refill line
mem_ack_i  in  1  one-cycle completion pulse

Behaviour:
- Interface: one clock, clk_i; rst_i synchronous, active-high.
- Address split: tag = addr[31:31-TAG_W+1], index = addr[IDX_W+4:5], word = addr[4:2]; addr[1:0] ignored.
- Arrays per line: valid, dirty, tag, data.
- Reset: valid and dirty cleared for all lines; state IDLE; mem_req_o=0, mem_we_o=0, cpu_stall_o=0, cpu_rdata_o=0. Data and tag contents are don't-care.
- FSM states: IDLE, WRITEBACK, ALLOCATE, REFILL.
- IDLE hit (cpu_req_i & valid & tag match):
  - cpu_stall_o=0 combinationally.
  - Load: cpu_rdata_o = selected word, same cycle.
  - Store: word written at the clock edge; dirty set.
- IDLE miss: cpu_stall_o=1 combinationally in the same cycle. Next state is WRITEBACK if valid & dirty, else ALLOCATE.
- WRITEBACK:
  - mem_req_o=1, mem_we_o=1, mem_addr_o = {stored tag, index, 5'b0}, mem_wdata_o = line.
  - On mem_ack_i -> ALLOCATE.
- ALLOCATE:
  - mem_req_o=1, mem_we_o=0, mem_addr_o = {cpu tag, index, 5'b0}.
  - On mem_ack_i: line = mem_rdata_i, valid=1, dirty=0, tag written -> REFILL.
- REFILL: single bubble; stall still 1; mem_req_o=0 -> IDLE, where the access now hits and completes (a store sets dirty there).
- Stall covers every cycle from miss detection through REFILL inclusive.
- Miss latency = 2 + (WB ack wait, if dirty) + (refill ack wait) cycles beyond the hit cycle.
- Request contract: while cpu_stall_o=1, cpu_req_i, cpu_we_i, cpu_addr_i and cpu_wdata_i are held stable by the frozen EX/MEM register.
- cpu_req_i=0: stall 0, no array or state change; cpu_rdata_o is don't-care but deterministic (selected word).
- mem_ack_i outside WRITEBACK/ALLOCATE is ignored.
- mem_req_o holds high until ack; there is no back-to-back request without an intervening state.
- Reset mid-transfer: the FSM returns to IDLE at the edge and mem_req_o drops the next cycle. The partial transfer is abandoned and the line stays invalid.

Optional Feature:
DCACHE_STATS_EN: when defined, adds outputs hit_cnt_o[31:0] and miss_cnt_o[31:0].
- hit_cnt_o increments once per completed access that hit on first lookup.
- miss_cnt_o increments once per miss, at the IDLE->WRITEBACK/ALLOCATE transition. The post-refill completion is not counted as a hit.
- Both counters saturate at 32'hFFFF_FFFF and clear on rst_i.
When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package dcache_pkg holds:
  - state enum (IDLE, WRITEBACK, ALLOCATE, REFILL)
  - LINE_BITS, WORD_BITS=32, OFFSET_W=5
  - address-field extraction functions
- Sub-module dcache_sram: valid/dirty/tag/data arrays. Asynchronous read, synchronous write with line-write and word-write-enable ports. Reset clears only valid and dirty.

Test Plan:
- Cold load 0x0000_0040 with memory line = word i -> value 0x100+i. Expect: stall 1; ALLOCATE request addr 0x40, we=0; ack after 3 cycles; REFILL; then rdata 0x100 and stall 0.
- Repeat load 0x0000_0044 immediately -> stall 0 same cycle, rdata 0x101, no mem_req_o.
- Store 0xDEADBEEF to 0x0000_0048 (hit), then load 0x0000_0448 (same index, different tag). Expect: WRITEBACK to addr 0x40 with mem_wdata_o word 2 = 0xDEADBEEF, then ALLOCATE to addr 0x440.
- Store miss to clean line 0x0000_0800 (index 0), value 0x12345678. Expect: ALLOCATE only, no WRITEBACK; afterwards line dirty and load 0x800 returns 0x12345678.
- Assert rst_i during ALLOCATE before ack. Expect: mem_req_o=0 next cycle, stall 0; subsequent load 0x40 misses again.
- DCACHE_STATS_EN defined, running the sequence above -> hit_cnt_o and miss_cnt_o match the scoreboard counts exactly.
